gate_unit_pipe: RTL and testbench

Parametrised, registered successor to the team's 2-input gate block. It applies one selectable bitwise gate function per transaction to WIDTH-bit operands. An optional accumulator mode chains results across transactions. Results are buffered in a 2-entry output queue behind a valid/ready handshake, so the unit can sit directly on a streaming datapath in place of the purely combinational gate block.

---
 rtl/gate_unit_pipe.sv | 148 ++++++++++++++
 tb/tb_gate_unit_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: registered bitwise gate unit with optional accumulator
// chaining and a 2-entry result queue behind a valid/ready handshake.
// The flags are computed once, when a result is pushed. The head of the
// queue is copied into output registers, so y and its flags keep the last
// popped value while the queue is empty.
module gate_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             all_ones,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    localparam int EW = WIDTH + 3;  // entry: {result, zero, all_ones, parity}

    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_res;
    logic [EW-1:0]    w_entry;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;
    logic             w_head_load;
    logic [EW-1:0]    w_head_next;

    logic [EW-1:0]    r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic             r_par;

    // Select the second operand and evaluate the gate function with its flags
    always_comb begin
        w_opb = acc_mode ? r_acc : b;
        w_res = '0;
        case (op)
            3'd0:    w_res = ~a;
            3'd1:    w_res = a & w_opb;
            3'd2:    w_res = a | w_opb;
            3'd3:    w_res = ~(a & w_opb);
            3'd4:    w_res = ~(a | w_opb);
            3'd5:    w_res = a ^ w_opb;
            3'd6:    w_res = ~(a ^ w_opb);
            default: w_res = a;
        endcase
        w_entry = {w_res, (w_res == '0), (&w_res), (^w_res)};
    end

    // Handshakes, next occupancy and the value that becomes the new head
    always_comb begin
        w_push      = in_valid && r_in_ready;
        w_pop       = (r_count != 2'd0) && out_ready;
        w_head_load = 1'b0;
        w_head_next = w_entry;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
        if (w_pop) begin
            // Full queue never pushes (in_ready is low), so the second slot
            // becomes head; with one entry a same-cycle push becomes head.
            if (r_count == 2'd2) begin
                w_head_load = 1'b1;
                w_head_next = r_mem[~r_rd_ptr];
            end else if (w_push) begin
                w_head_load = 1'b1;
            end
        end else if ((r_count == 2'd0) && w_push) begin
            w_head_load = 1'b1;
        end
    end

    // Queue storage: each slot captures the pushed entry when the write pointer selects it
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= w_entry;
                end
            end
        end
    endgenerate

    // Pointers, occupancy, registered in_ready, accumulator and head output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_acc      <= '0;
            r_y        <= '0;
            r_zero     <= 1'b1;
            r_ones     <= 1'b0;
            r_par      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
            // Clear wins over the chained update; the operand already used the old value
            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_push && acc_mode) begin
                r_acc <= w_res;
            end
            if (w_head_load) begin
                r_y    <= w_head_next[EW-1:3];
                r_zero <= w_head_next[2];
                r_ones <= w_head_next[1];
                r_par  <= w_head_next[0];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign y         = r_y;
    assign zero      = r_zero;
    assign all_ones  = r_ones;
    assign parity    = r_par;
    assign acc       = r_acc;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe: directed and randomized stimulus checked against a
// queue-based reference model that evaluates each gate from per-op truth tables.
module tb_gate_unit_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             all_ones;
    logic             parity;
    logic [WIDTH-1:0] acc;

    gate_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_mode  (acc_mode),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .all_ones  (all_ones),
        .parity    (parity),
        .acc       (acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             o;
        logic             p;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] m_acc;
    logic             m_rdy;
    logic [3:0]       tt_tab [0:7];   // bit {a,b} of entry = gate output
    logic [WIDTH-1:0] tbl [0:7];
    logic [WIDTH-1:0] chain_a [0:3];
    logic [WIDTH-1:0] chain_y [0:3];
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t ref_eval(input logic [2:0] f, input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] s);
        ent_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            e.r[i] = tt_tab[f][{x[i], s[i]}];
            ones += int'(e.r[i]);
        end
        e.z = (ones == 0);
        e.o = (ones == WIDTH);
        e.p = ones[0];
        return e;
    endfunction

    // One clock: update the model with the pre-edge inputs, then compare after the edge.
    task automatic step();
        ent_t e;
        logic push;
        logic pop;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_acc = '0;
            m_rdy = 1'b1;
        end else begin
            push = in_valid && m_rdy;
            pop  = (q.size() != 0) && out_ready;
            e    = ref_eval(op, a, acc_mode ? m_acc : b);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            m_rdy = (q.size() < 2);
            if (acc_clr) m_acc = '0;
            else if (push && acc_mode) m_acc = e.r;
        end
        #1;
        check("in_ready", in_ready, m_rdy);
        check("out_valid", out_valid, (q.size() != 0));
        check("acc", acc, m_acc);
        if (q.size() != 0) begin
            check("y", y, q[0].r);
            check("zero", zero, q[0].z);
            check("all_ones", all_ones, q[0].o);
            check("parity", parity, q[0].p);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_zero"}, zero, 1);
        check({tag, "_all_ones"}, all_ones, 0);
        check({tag, "_parity"}, parity, 0);
        check({tag, "_acc"}, acc, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tt_tab[0] = 4'b0011; tt_tab[1] = 4'b1000; tt_tab[2] = 4'b1110; tt_tab[3] = 4'b0111;
        tt_tab[4] = 4'b0001; tt_tab[5] = 4'b0110; tt_tab[6] = 4'b1001; tt_tab[7] = 4'b1100;
        tbl[0] = 8'h0F; tbl[1] = 8'hC0; tbl[2] = 8'hFC; tbl[3] = 8'h3F;
        tbl[4] = 8'h03; tbl[5] = 8'h3C; tbl[6] = 8'hC3; tbl[7] = 8'hF0;
        chain_a[0] = 8'h01; chain_a[1] = 8'h02; chain_a[2] = 8'h04; chain_a[3] = 8'h80;
        chain_y[0] = 8'h01; chain_y[1] = 8'h03; chain_y[2] = 8'h07; chain_y[3] = 8'h87;
        m_acc = '0;
        m_rdy = 1'b1;

        // Reset state
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; acc_mode = 1'b0;
        a = '0; b = '0; acc_clr = 1'b0; out_ready = 1'b0;
        #2;
        check_reset_vals("por");
        step();
        #3 rst = 1'b0;
        step();

        // Truth table, back-to-back, latency 1
        out_ready = 1'b1; in_valid = 1'b1; a = 8'hF0; b = 8'hCC;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            step();
            check($sformatf("tt_op%0d_y", k), y, tbl[k]);
        end
        in_valid = 1'b0;
        step();
        step();

        // Accumulator chain
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0; acc_mode = 1'b1; op = 3'd2; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = chain_a[k];
            step();
            check($sformatf("chain%0d_y", k), y, chain_y[k]);
        end
        check("chain_acc", acc, 8'h87);
        op = 3'd5; a = 8'h87;
        step();
        check("chain_xor_y", y, 8'h00);
        check("chain_xor_zero", zero, 1);
        check("chain_xor_acc", acc, 8'h00);
        in_valid = 1'b0; acc_mode = 1'b0;
        step();

        // Backpressure: exactly two accepts, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7;
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            step();
        end
        check("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_in_ready_rise", in_ready, 1);
        step();
        step();

        // Clear and chained accept in the same cycle
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0; in_valid = 1'b1; acc_mode = 1'b1; op = 3'd2; a = 8'h55;
        step();
        check("sim_pre_acc", acc, 8'h55);
        acc_clr = 1'b1; op = 3'd1; a = 8'hFF;
        step();
        check("sim_y", y, 8'h55);
        check("sim_acc", acc, 8'h00);
        acc_clr = 1'b0; in_valid = 1'b0; acc_mode = 1'b0;
        step();

        // Randomized traffic against the model
        for (int k = 0; k < 1000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            op        = 3'($urandom_range(0, 7));
            acc_mode  = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 15) == 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            step();
        end

        // Asynchronous reset with two entries queued and acc = AA
        acc_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        acc_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; acc_mode = 1'b1;
        op = 3'd2; a = 8'hAA;
        step();
        acc_mode = 1'b0; a = 8'h5A; b = 8'h0F; op = 3'd5;
        step();
        check("pre_rst_acc", acc, 8'hAA);
        check("pre_rst_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async");
        step();
        #3 rst = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_acc", acc, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
